// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // A stop period longer than one bit needs an extra tick-counter bit.
  function automatic int sreg_width(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Handshake bundle between the TX FIFO/baud generator side and the serializer.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            tx;

  modport master (
    output s_tick, tx_start, din,
    input  tx_busy, tx_done_tick, tx
  );

  modport slave (
    input  s_tick, tx_start, din,
    output tx_busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART serializer: start bit, DBIT data bits LSB-first, optional parity, stop period.
// tx_done_tick marks end of frame and doubles as the FIFO pop strobe.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = PAR_NONE
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int SW = sreg_width(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          b_d     = bus.din;
          s_d     = '0;
          p_d     = (PARITY == PAR_ODD) ? ~^bus.din : ^bus.din;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bus.s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_STOP: begin
        if (bus.s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered, so tx changes on the
    // same edge as the state and never glitches.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
      ST_PARITY: tx_d = p_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and a 2-stop-bit sparse-tick build.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st [4];
  logic [7:0] dn [4];
  logic       o_tx [4];
  logic       o_busy [4];
  logic       o_done [4];
  logic       tick3 = 1'b0;
  int         tcnt = 0;
  int         nvec = 0;
  int         nfail = 0;

  always #5 clk = ~clk;

  // Sparse tick: one pulse every 54 clks, updated well clear of the edges.
  always @(posedge clk) begin
    #3;
    tcnt  = (tcnt == 53) ? 0 : tcnt + 1;
    tick3 = (tcnt == 0);
  end

  uart_tx_if #(.DBIT(8)) i0 ();
  uart_tx_if #(.DBIT(8)) i1 ();
  uart_tx_if #(.DBIT(8)) i2 ();
  uart_tx_if #(.DBIT(8)) i3 ();

  assign i0.s_tick = 1'b1;  assign i0.tx_start = st[0];  assign i0.din = dn[0];
  assign i1.s_tick = 1'b1;  assign i1.tx_start = st[1];  assign i1.din = dn[1];
  assign i2.s_tick = 1'b1;  assign i2.tx_start = st[2];  assign i2.din = dn[2];
  assign i3.s_tick = tick3; assign i3.tx_start = st[3];  assign i3.din = dn[3];

  assign o_tx[0] = i0.tx;  assign o_busy[0] = i0.tx_busy;  assign o_done[0] = i0.tx_done_tick;
  assign o_tx[1] = i1.tx;  assign o_busy[1] = i1.tx_busy;  assign o_done[1] = i1.tx_done_tick;
  assign o_tx[2] = i2.tx;  assign o_busy[2] = i2.tx_busy;  assign o_done[2] = i2.tx_done_tick;
  assign o_tx[3] = i3.tx;  assign o_busy[3] = i3.tx_busy;  assign o_done[3] = i3.tx_done_tick;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u0 (.clk(clk), .reset(reset), .bus(i0));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u1 (.clk(clk), .reset(reset), .bus(i1));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u2 (.clk(clk), .reset(reset), .bus(i2));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u3 (.clk(clk), .reset(reset), .bus(i3));

  task automatic chk(input string tag, input int j, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s @%0d: observed %b expected %b", tag, j, obs, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag, input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      chk({tag, " tx"}, j, o_tx[d], 1'b1);
      chk({tag, " busy"}, j, o_busy[d], 1'b0);
      chk({tag, " done"}, j, o_done[d], 1'b0);
      @(negedge clk);
    end
  endtask

  // Present a byte for one accepting edge; returns at the negedge after acceptance.
  task automatic start(input int d, input logic [7:0] data);
    st[d] = 1'b1;
    dn[d] = data;
    @(negedge clk);
    st[d] = 1'b0;
    dn[d] = ~data;
  endtask

  // Called at the negedge right after the accepting edge (j = 0). bits[0] is the
  // start bit, then data LSB-first, then parity; the line is high after nb bits.
  // Returns at negedge j = done_at + 1 without advancing further.
  task automatic check_frame(input int d, input string tag, input logic [15:0] bits,
                             input int nb, input int bl, input int done_at, input int poke_at);
    logic exp_tx;
    for (int j = 0; j <= done_at + 1; j++) begin
      if (j == poke_at) begin st[d] = 1'b1; dn[d] = 8'h3C; end
      if (j == poke_at + 1) st[d] = 1'b0;
      if (j <= done_at) begin
        exp_tx = (j < nb * bl) ? bits[j / bl] : 1'b1;
        chk({tag, " tx"}, j, o_tx[d], exp_tx);
        chk({tag, " busy"}, j, o_busy[d], (j < done_at));
      end
      chk({tag, " done"}, j, o_done[d], (j == done_at));
      if (j <= done_at) @(negedge clk);
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin st[d] = 1'b0; dn[d] = 8'h00; end

    // Reset state on every instance.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk("rst tx", d, o_tx[d], 1'b1);
      chk("rst busy", d, o_busy[d], 1'b0);
      chk("rst done", d, o_done[d], 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Basic frame 0xA5, no parity: 0,1,0,1,0,0,1,0,1 then stop; done at 160.
    start(0, 8'hA5);
    check_frame(0, "a5", 16'h014A, 9, 16, 160, -10);
    @(negedge clk);
    chk_idle(0, "a5 after", 4);

    // Busy ignore: 0x3C pulsed mid-DATA must not change or extend the frame.
    start(0, 8'hA5);
    check_frame(0, "ignore", 16'h014A, 9, 16, 160, 40);
    @(negedge clk);
    chk_idle(0, "ignore after", 40);

    // Parity on 0x07: even -> 1, odd -> 0; done at 176.
    start(1, 8'h07);
    check_frame(1, "even", 16'h020E, 10, 16, 176, -10);
    @(negedge clk);
    start(2, 8'h07);
    check_frame(2, "odd", 16'h000E, 10, 16, 176, -10);
    @(negedge clk);
    chk_idle(2, "odd after", 4);

    // Back-to-back with tx_start held: next start bit 1 clk after done.
    st[0] = 1'b1;
    dn[0] = 8'h55;
    @(negedge clk);
    dn[0] = 8'hF0;
    check_frame(0, "b2b 55", 16'h00AA, 9, 16, 160, -10);
    st[0] = 1'b0;
    dn[0] = 8'h00;
    check_frame(0, "b2b f0", 16'h01E0, 9, 16, 160, -10);
    @(negedge clk);
    chk_idle(0, "b2b after", 4);

    // Mid-frame reset during data bit 2 of 0x5A (a 0 on the line).
    start(0, 8'h5A);
    repeat (50) @(negedge clk);
    chk("pre-rst tx", 50, o_tx[0], 1'b0);
    chk("pre-rst busy", 50, o_busy[0], 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async rst tx", 0, o_tx[0], 1'b1);
    chk("async rst busy", 0, o_busy[0], 1'b0);
    chk("async rst done", 0, o_done[0], 1'b0);
    @(negedge clk);
    reset = 1'b0;
    chk_idle(0, "post-rst", 200);
    start(0, 8'hC3);
    check_frame(0, "c3", 16'h0186, 9, 16, 160, -10);
    @(negedge clk);

    // Sparse tick, 2 stop bits: bit = 864 clks, done at 176*54 = 9504.
    begin
      int k;
      k = 0;
      while (!tick3 && k < 60) begin
        @(negedge clk);
        k++;
      end
      chk("tick3 align", k, tick3, 1'b1);
    end
    start(3, 8'hA5);
    check_frame(3, "sparse", 16'h014A, 9, 864, 9504, -10);
    @(negedge clk);
    chk_idle(3, "sparse after", 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
